thread_lsu: RTL and testbench

- Per-thread load/store unit. It turns LDR/STR into memory requests and returns loaded data to the thread's register file on lsu_out.
- One instance sits beside each thread's register file inside a core. It consumes rs/rt, produced during REQUEST, and feeds lsu_out, consumed during UPDATE.
- It drives a valid/ready handshake toward the core's memory controller channel.
- It reports progress on lsu_state, which the scheduler polls during WAIT.

---
 rtl/states_pkg.sv | 24 ++
 rtl/thread_lsu.sv | 147 ++++++++++++++
 tb/tb_thread_lsu.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/states_pkg.sv
// Shared state encodings for the core sequencer and the per-thread load/store unit.
package states_pkg;

    // Core pipeline phase broadcast to every thread.
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    // Progress of one thread's memory access, polled by the scheduler.
    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: turns LDR/STR into a single outstanding
// valid/ready request on the read or write channel and captures load data.
module thread_lsu
    import states_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [7:0]           rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);

    // Number of operand bits that actually reach the address / data fields.
    localparam int ACP = (ADDR_BITS < 8) ? ADDR_BITS : 8;
    localparam int DCP = (DATA_BITS < 8) ? DATA_BITS : 8;

    lsu_state_t           state_q, state_d;
    logic                 op_read_q, op_read_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;
    logic [ADDR_BITS-1:0] addr_s;
    logic [DATA_BITS-1:0] data_s;

    // Next-state logic: everything holds unless enabled; read wins over write.
    always_comb begin
        state_d    = state_q;
        op_read_d  = op_read_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        lsu_out_d  = lsu_out_q;
        addr_s     = '0;
        addr_s[ACP-1:0] = rs[ACP-1:0];
        data_s     = '0;
        data_s[DCP-1:0] = rt[DCP-1:0];
        if (enable) begin
            case (state_q)
                LSU_IDLE: begin
                    if ((core_state == CORE_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        op_read_d = decoded_mem_read_enable;
                        state_d   = LSU_REQUESTING;
                    end else begin
                        state_d = LSU_IDLE;
                    end
                end
                LSU_REQUESTING: begin
                    if (op_read_q) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = addr_s;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_s;
                        wr_data_d  = data_s;
                    end
                    state_d = LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (op_read_q) begin
                        if (mem_read_ready) begin
                            lsu_out_d  = mem_read_data;
                            rd_valid_d = 1'b0;
                            state_d    = LSU_DONE;
                        end else begin
                            state_d = LSU_WAITING;
                        end
                    end else begin
                        if (mem_write_ready) begin
                            wr_valid_d = 1'b0;
                            state_d    = LSU_DONE;
                        end else begin
                            state_d = LSU_WAITING;
                        end
                    end
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        state_d = LSU_IDLE;
                    end else begin
                        state_d = LSU_DONE;
                    end
                end
                default: begin
                    state_d    = LSU_IDLE;
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LSU_IDLE;
            op_read_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            lsu_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_read_q  <= op_read_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            lsu_out_q  <= lsu_out_d;
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = lsu_out_q;

endmodule

// File: tb/tb_thread_lsu.sv
// Directed bench for thread_lsu: each task drives one scenario and checks inline.
module tb_thread_lsu;

    localparam logic [2:0] C_REQUEST = 3'd3;
    localparam logic [2:0] C_WAIT    = 3'd4;
    localparam logic [2:0] C_EXECUTE = 3'd5;
    localparam logic [2:0] C_UPDATE  = 3'd6;
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_REQ     = 2'b01;
    localparam logic [1:0] S_WAIT    = 2'b10;
    localparam logic [1:0] S_DONE    = 2'b11;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] rs;
    logic [7:0] rt;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready;
    logic [7:0] mem_read_data;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;

    int checks = 0;
    int errors = 0;

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (lsu_state !== S_IDLE) begin $display("FAIL reset_state got %0h want %0h", lsu_state, S_IDLE); errors++; end
        checks++; if (mem_read_valid !== 1'b0) begin $display("FAIL reset_rvalid got %0b want 0", mem_read_valid); errors++; end
        checks++; if (mem_write_valid !== 1'b0) begin $display("FAIL reset_wvalid got %0b want 0", mem_write_valid); errors++; end
        checks++; if (mem_read_address !== 8'h00 || mem_write_address !== 8'h00 || mem_write_data !== 8'h00) begin
            $display("FAIL reset_addr_data got %0h/%0h/%0h want 0/0/0", mem_read_address, mem_write_address, mem_write_data); errors++; end
        checks++; if (lsu_out !== 8'h00) begin $display("FAIL reset_out got %0h want 00", lsu_out); errors++; end
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_load_immediate();
        core_state = C_REQUEST; rd_en = 1'b1; rs = 8'h2A;
        mem_read_ready = 1'b1; mem_read_data = 8'h5C;
        tick();
        core_state = C_WAIT;
        checks++; if (lsu_state !== S_REQ || mem_read_valid !== 1'b0) begin
            $display("FAIL ld_requesting got state %0h valid %0b want 1 0", lsu_state, mem_read_valid); errors++; end
        tick();
        checks++; if (lsu_state !== S_WAIT || mem_read_valid !== 1'b1 || mem_read_address !== 8'h2A) begin
            $display("FAIL ld_valid got state %0h valid %0b addr %0h want 2 1 2a", lsu_state, mem_read_valid, mem_read_address); errors++; end
        tick();
        checks++; if (lsu_state !== S_DONE || mem_read_valid !== 1'b0 || lsu_out !== 8'h5C) begin
            $display("FAIL ld_done got state %0h valid %0b out %0h want 3 0 5c", lsu_state, mem_read_valid, lsu_out); errors++; end
        core_state = C_UPDATE; rd_en = 1'b0; mem_read_ready = 1'b0;
        tick();
        checks++; if (lsu_state !== S_IDLE) begin $display("FAIL ld_update got %0h want 0", lsu_state); errors++; end
    endtask

    task automatic test_store_stall();
        core_state = C_REQUEST; wr_en = 1'b1; rs = 8'h10; rt = 8'hA7; mem_write_ready = 1'b0;
        tick();
        // Operation already latched; flipping the decode must not turn it into a read.
        core_state = C_WAIT; wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rs = 8'hFF; rt = 8'h00;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h10 || mem_write_data !== 8'hA7 || mem_read_valid !== 1'b0) begin
                $display("FAIL st_stall%0d got wv %0b addr %0h data %0h rv %0b want 1 10 a7 0", i, mem_write_valid, mem_write_address, mem_write_data, mem_read_valid); errors++; end
            if (i < 2) tick();
        end
        mem_write_ready = 1'b1;
        tick();
        checks++; if (lsu_state !== S_DONE || mem_write_valid !== 1'b0 || lsu_out !== 8'h5C) begin
            $display("FAIL st_done got state %0h wv %0b out %0h want 3 0 5c", lsu_state, mem_write_valid, lsu_out); errors++; end
        core_state = C_UPDATE; rd_en = 1'b0; mem_write_ready = 1'b0;
        tick();
        checks++; if (lsu_state !== S_IDLE) begin $display("FAIL st_update got %0h want 0", lsu_state); errors++; end
    endtask

    task automatic test_both_enables();
        core_state = C_REQUEST; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h03; rt = 8'hEE;
        mem_read_ready = 1'b0;
        tick();
        core_state = C_WAIT;
        checks++; if (mem_write_valid !== 1'b0) begin $display("FAIL both_req_wv got %0b want 0", mem_write_valid); errors++; end
        tick();
        checks++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h03 || mem_write_valid !== 1'b0) begin
            $display("FAIL both_valid got rv %0b addr %0h wv %0b want 1 03 0", mem_read_valid, mem_read_address, mem_write_valid); errors++; end
        // Write ready alone must not complete a read.
        mem_write_ready = 1'b1;
        tick();
        checks++; if (lsu_state !== S_WAIT || mem_read_valid !== 1'b1) begin
            $display("FAIL both_wready_ignored got state %0h rv %0b want 2 1", lsu_state, mem_read_valid); errors++; end
        mem_read_ready = 1'b1; mem_read_data = 8'h99;
        tick();
        checks++; if (lsu_state !== S_DONE || lsu_out !== 8'h99 || mem_write_valid !== 1'b0) begin
            $display("FAIL both_done got state %0h out %0h wv %0b want 3 99 0", lsu_state, lsu_out, mem_write_valid); errors++; end
        core_state = C_UPDATE; rd_en = 1'b0; wr_en = 1'b0; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        tick();
    endtask

    task automatic test_enable_freeze();
        enable = 1'b0; core_state = C_REQUEST; rd_en = 1'b1; rs = 8'h44;
        tick(); tick();
        checks++; if (lsu_state !== S_IDLE || mem_read_valid !== 1'b0) begin
            $display("FAIL dis_idle got state %0h rv %0b want 0 0", lsu_state, mem_read_valid); errors++; end
        enable = 1'b1;
        tick();
        core_state = C_WAIT;
        tick();
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (lsu_state !== S_WAIT || mem_read_valid !== 1'b1 || mem_read_address !== 8'h44 || lsu_out !== 8'h99) begin
                $display("FAIL frozen%0d got state %0h rv %0b addr %0h out %0h want 2 1 44 99", i, lsu_state, mem_read_valid, mem_read_address, lsu_out); errors++; end
        end
        enable = 1'b1;
        tick();
        checks++; if (lsu_state !== S_DONE || lsu_out !== 8'h3C || mem_read_valid !== 1'b0) begin
            $display("FAIL unfreeze got state %0h out %0h rv %0b want 3 3c 0", lsu_state, lsu_out, mem_read_valid); errors++; end
        core_state = C_UPDATE; rd_en = 1'b0; mem_read_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        core_state = C_REQUEST; rd_en = 1'b1; rs = 8'h55;
        tick();
        core_state = C_WAIT;
        tick();
        checks++; if (mem_read_valid !== 1'b1) begin $display("FAIL rstmid_pre got rv %0b want 1", mem_read_valid); errors++; end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_read_valid !== 1'b0 || lsu_state !== S_IDLE || lsu_out !== 8'h00 || mem_read_address !== 8'h00) begin
            $display("FAIL rstmid got rv %0b state %0h out %0h addr %0h want 0 0 00 00", mem_read_valid, lsu_state, lsu_out, mem_read_address); errors++; end
        rd_en = 1'b0; core_state = C_EXECUTE;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_done_persist();
        core_state = C_REQUEST; rd_en = 1'b1; rs = 8'h07; mem_read_ready = 1'b1; mem_read_data = 8'h11;
        tick();
        core_state = C_WAIT;
        tick(); tick();
        core_state = C_EXECUTE; mem_read_data = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (lsu_state !== S_DONE || lsu_out !== 8'h11) begin
                $display("FAIL done_hold%0d got state %0h out %0h want 3 11", i, lsu_state, lsu_out); errors++; end
        end
        core_state = C_REQUEST; rs = 8'h08;
        tick(); tick();
        checks++; if (lsu_state !== S_DONE || mem_read_valid !== 1'b0) begin
            $display("FAIL done_req_ignored got state %0h rv %0b want 3 0", lsu_state, mem_read_valid); errors++; end
        core_state = C_UPDATE; rd_en = 1'b0;
        tick(); tick();
        checks++; if (lsu_state !== S_IDLE || mem_read_valid !== 1'b0 || lsu_out !== 8'h11) begin
            $display("FAIL done_update got state %0h rv %0b out %0h want 0 0 11", lsu_state, mem_read_valid, lsu_out); errors++; end
        mem_read_ready = 1'b0;
    endtask

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; core_state = C_EXECUTE; rd_en = 1'b0; wr_en = 1'b0;
        rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
        test_reset();
        test_load_immediate();
        test_store_stall();
        test_both_enables();
        test_enable_freeze();
        test_reset_mid();
        test_done_persist();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
